// File: rtl/dmem_arbiter_pkg.sv
// Shared owner-state encoding and default DMEM geometry for the data-memory arbiter.
// Imported by dmem_arbiter; holds no logic beyond a counter-width helper.
package dmem_arbiter_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_EXT = 1'b1
  } owner_e;

  localparam int DMEM_ADDR_W = 11;
  localparam int DMEM_DATA_W = 32;

  // Width of a counter that must hold the values 0 .. n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Purpose: shares one DMEM port between the CPU data port and an external loader/debug master.
// Latency: CPU and ext writes commit at the granting edge; ext reads return one cycle after grant.
// Backpressure: CPU is stalled while the ext side owns DMEM; ext_req is held until ext_gnt.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_cs,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              dm_ena,
  output logic              dm_w,
  output logic              dm_r,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int WAIT_W = cnt_w(MAX_WAIT);
  localparam int BEAT_W = cnt_w(BURST_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

  owner_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic              ext_rd_beat;

  // Port mux is selected purely by the registered owner, never by the live requests.
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    beat_nxt  = '0;
    dm_ena    = cpu_cs;
    dm_w      = cpu_wr;
    dm_r      = cpu_rd;
    dm_addr   = cpu_addr;
    dm_wdata  = cpu_wdata;
    cpu_rdata = dm_rdata;
    cpu_stall = 1'b0;
    ext_gnt   = 1'b0;

    if (state == S_CPU) begin
      if (ext_req && (!cpu_cs || wait_cnt == WAIT_LAST)) begin
        state_nxt = S_EXT;
      end else if (ext_req) begin
        // Only reachable with cpu_cs set and wait_cnt below WAIT_LAST, so no wrap.
        wait_nxt = wait_cnt + 1'b1;
      end
    end else begin
      dm_ena    = ext_req;
      dm_w      = ext_req & ext_we;
      dm_r      = ext_req & ~ext_we;
      dm_addr   = ext_addr;
      dm_wdata  = ext_wdata;
      cpu_rdata = '0;
      cpu_stall = cpu_cs;
      ext_gnt   = ext_req;

      if (!ext_req || (cpu_cs && beat_cnt == BEAT_LAST)) begin
        state_nxt = S_CPU;
      end else begin
        // Saturates so a long idle-CPU burst still yields promptly once the CPU arrives.
        beat_nxt = (beat_cnt == BEAT_LAST) ? beat_cnt : beat_cnt + 1'b1;
      end
    end
  end

  assign ext_rd_beat = ext_gnt & ~ext_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      beat_cnt   <= '0;
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      beat_cnt   <= beat_nxt;
      ext_rvalid <= ext_rd_beat;
      if (ext_rd_beat) begin
        ext_rdata <= dm_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a DMEM model, a reference memory and a read-return scoreboard.
module tb_dmem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          cpu_cs, cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_gnt, ext_rvalid;
  logic          dm_ena, dm_w, dm_r;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;

  bit   [DW-1:0] mem     [0:2047];
  bit   [DW-1:0] ref_mem [0:2047];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read, edge-write DMEM.
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_ena && dm_w) mem[dm_addr] <= dm_wdata;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants, read-return scoreboard and reference memory updates.
  always @(negedge clk) begin
    chk("gnt_without_stall", {31'b0, ext_gnt & ~cpu_stall & cpu_cs}, 32'd0);
    chk("cpu_owns_while_stalled", {31'b0, dm_ena & ~ext_gnt & (cpu_stall | ~cpu_cs)}, 32'd0);
    if (ext_gnt) chk("ext_dm_addr", {21'b0, dm_addr}, {21'b0, ext_addr});
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk("ext_rvalid", {31'b0, ext_rvalid}, 32'd1);
      chk("ext_rdata", ext_rdata, exp_v);
    end else begin
      chk("ext_rvalid_idle", {31'b0, ext_rvalid}, 32'd0);
    end
    if (rst) begin
      if (cpu_cs && cpu_rd && !cpu_stall)
        chk("cpu_rdata_ref", cpu_rdata, ref_mem[cpu_addr]);
      if (ext_gnt && !ext_we) exp_q.push_back(ref_mem[ext_addr]);
      if (ext_gnt && ext_we) ref_mem[ext_addr] = ext_wdata;
      if (cpu_cs && cpu_wr && !cpu_stall && !ext_gnt) ref_mem[cpu_addr] = cpu_wdata;
    end
  end

  initial begin
    rst = 1'b0;
    cpu_cs = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

    // Reset state and combinational CPU pass-through under reset
    cyc();
    cyc();
    cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 11'h005;
    #2;
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_gnt", {31'b0, ext_gnt}, 32'd0);
    chk("rst_rvalid", {31'b0, ext_rvalid}, 32'd0);
    chk("rst_rdata", ext_rdata, 32'd0);
    chk("rst_dm_ena", {31'b0, dm_ena}, 32'd1);
    chk("rst_dm_addr", {21'b0, dm_addr}, 32'h005);

    // Ext write with CPU idle
    cyc();
    rst = 1'b1;
    cpu_cs = 1'b0; cpu_rd = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 11'h010; ext_wdata = 32'hDEADBEEF;
    #2;
    chk("wr_c0_gnt", {31'b0, ext_gnt}, 32'd0);
    cyc();
    #2;
    chk("wr_c1_gnt", {31'b0, ext_gnt}, 32'd1);
    chk("wr_c1_dm_w", {31'b0, dm_w}, 32'd1);

    // Ext read back of the same word, still owning DMEM
    cyc();
    ext_we = 1'b0;
    #2;
    chk("wr_committed", mem[11'h010], 32'hDEADBEEF);
    chk("rd_gnt", {31'b0, ext_gnt}, 32'd1);
    cyc();
    ext_req = 1'b0;
    #2;
    chk("rd_rvalid", {31'b0, ext_rvalid}, 32'd1);
    chk("rd_rdata", ext_rdata, 32'hDEADBEEF);
    cyc();
    #2;
    chk("rd_rvalid_once", {31'b0, ext_rvalid}, 32'd0);

    // CPU write then read in S_CPU
    cyc();
    cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h020; cpu_wdata = 32'h12345678;
    #2;
    chk("cpu_wr_stall", {31'b0, cpu_stall}, 32'd0);
    cyc();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    #2;
    chk("cpu_rd_data", cpu_rdata, 32'h12345678);

    // Contention: CPU busy every cycle, ext reads held; 8 starved cycles, 4 beats, repeat
    cyc();
    cpu_addr = 11'h010;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h020;
    for (int c = 0; c < 30; c++) begin
      #2;
      chk($sformatf("cont_gnt_c%0d", c), {31'b0, ext_gnt}, {31'b0, (c % 12) >= 8});
      chk($sformatf("cont_stall_c%0d", c), {31'b0, cpu_stall}, {31'b0, (c % 12) >= 8});
      chk($sformatf("cont_cpu_rdata_c%0d", c), cpu_rdata,
          ((c % 12) >= 8) ? 32'h0 : 32'hDEADBEEF);
      cyc();
    end
    ext_req = 1'b0; cpu_cs = 1'b0; cpu_rd = 1'b0;

    // Unbounded burst while CPU idle
    cyc();
    ext_req = 1'b1; ext_addr = 11'h010;
    #2;
    chk("idle_burst_c0", {31'b0, ext_gnt}, 32'd0);
    for (int b = 0; b < 6; b++) begin
      cyc();
      #2;
      chk($sformatf("idle_burst_b%0d", b), {31'b0, ext_gnt}, 32'd1);
    end
    cyc();
    ext_req = 1'b0;
    cyc();

    // Reset during 2nd beat of an ext read burst
    cyc();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h020;
    #2;
    chk("rst_burst_c0", {31'b0, ext_gnt}, 32'd0);
    cyc();
    #2;
    chk("rst_burst_b1", {31'b0, ext_gnt}, 32'd1);
    cyc();
    rst = 1'b0;
    #2;
    chk("rst_burst_b2", {31'b0, ext_gnt}, 32'd1);
    cyc();
    rst = 1'b1;
    #2;
    chk("rst_burst_after_gnt", {31'b0, ext_gnt}, 32'd0);
    chk("rst_burst_after_rvalid", {31'b0, ext_rvalid}, 32'd0);
    chk("rst_burst_after_stall", {31'b0, cpu_stall}, 32'd0);
    ext_req = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
